// File: rtl/arbitro_salida_pkg.sv
// Shared definitions for the egress arbiter: widths, FSM encoding, counter selector
// and the round-robin search used to pick the next port.
package arbitro_salida_pkg;
  localparam int TAMANO_DATOS = 12;
  localparam int CONT_W       = 5;
  localparam int NUM_PUERTOS  = 4;
  localparam logic [2:0] IDX_TOTAL = 3'b100;

  typedef enum logic [1:0] {
    INICIO = 2'd0,
    ACTIVO = 2'd1,
    PAUSA  = 2'd2
  } estado_t;

  typedef logic [TAMANO_DATOS-1:0] dato_t;
  typedef logic [CONT_W-1:0]       cuenta_t;

  // Returns {hit, port}: first ready port scanning upward from ptr, mod 4.
  function automatic logic [2:0] buscar_grant(input logic [NUM_PUERTOS-1:0] listo,
                                              input logic [1:0] ptr);
    logic [2:0] r;
    logic [1:0] p;
    r = 3'b000;
    for (int i = NUM_PUERTOS - 1; i >= 0; i--) begin
      p = ptr + 2'(i);
      if (listo[p]) r = {1'b1, p};
    end
    return r;
  endfunction
endpackage

// File: rtl/arbitro_salida_if.sv
// FIFO-side, egress and counter-read signals of the output arbiter.
interface arbitro_salida_if;
  import arbitro_salida_pkg::*;

  logic [NUM_PUERTOS-1:0] fifo_empty;
  dato_t                  data_in4;
  dato_t                  data_in5;
  dato_t                  data_in6;
  dato_t                  data_in7;
  logic                   pausa;
  logic [NUM_PUERTOS-1:0] pop;
  dato_t                  data_out;
  logic                   valid_out;
  logic                   req;
  logic [2:0]             idx;
  cuenta_t                cuenta;
  logic                   valid_cuenta;

  modport master (
    input  fifo_empty, data_in4, data_in5, data_in6, data_in7, pausa, req, idx,
    output pop, data_out, valid_out, cuenta, valid_cuenta
  );

  modport slave (
    output fifo_empty, data_in4, data_in5, data_in6, data_in7, pausa, req, idx,
    input  pop, data_out, valid_out, cuenta, valid_cuenta
  );
endinterface

// File: rtl/arbitro_salida_contadores.sv
// Per-port and total forwarded-word counters with a registered req/idx read port.
module contadores_salida
  import arbitro_salida_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       incr,
  input  logic [1:0] puerto,
  input  logic       req,
  input  logic [2:0] idx,
  output cuenta_t    cuenta,
  output logic       valid_cuenta
);
  cuenta_t cnt [NUM_PUERTOS];
  cuenta_t total;
  cuenta_t lectura;

  always_comb begin
    lectura = '0;
    case (idx)
      3'd0, 3'd1, 3'd2, 3'd3: lectura = cnt[idx[1:0]];
      IDX_TOTAL:              lectura = total;
      default:                lectura = '0;
    endcase
  end

  // Read sees the value before this edge's increment.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_PUERTOS; i++) cnt[i] <= '0;
      total        <= '0;
      cuenta       <= '0;
      valid_cuenta <= 1'b0;
    end else begin
      if (incr) begin
        cnt[puerto] <= cnt[puerto] + CONT_W'(1);
        total       <= total + CONT_W'(1);
      end
      valid_cuenta <= req;
      if (req) cuenta <= lectura;
    end
  end
endmodule

// File: rtl/arbitro_salida.sv
// Round-robin drain of FIFOs 4..7 onto one egress bus, with downstream pause
// and forwarded-word counters.
module arbitro_salida
  import arbitro_salida_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  arbitro_salida_if.master bus
);
  estado_t                estado;
  logic [1:0]             ptr;
  logic                   habilita;
  logic                   hay_grant;
  logic [1:0]             g;
  logic                   grant;
  logic [NUM_PUERTOS-1:0] pop_c;
  logic [1:0]             puerto_p1;
  logic                   vld_p1;
  dato_t                  dato_sel;

  // Stage 0: combinational grant, gated by state and by pausa in the same cycle.
  always_comb begin
    habilita       = (estado == ACTIVO) && !bus.pausa;
    {hay_grant, g} = buscar_grant(~bus.fifo_empty, ptr);
    grant          = habilita && hay_grant;
    pop_c          = '0;
    if (grant) pop_c[g] = 1'b1;
  end

  assign bus.pop = pop_c;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      estado    <= INICIO;
      ptr       <= 2'd0;
      vld_p1    <= 1'b0;
      puerto_p1 <= 2'd0;
    end else begin
      case (estado)
        INICIO:  estado <= ACTIVO;
        ACTIVO:  if (bus.pausa) estado <= PAUSA;
        PAUSA:   if (!bus.pausa) estado <= ACTIVO;
        default: estado <= INICIO;
      endcase
      vld_p1 <= grant;
      if (grant) begin
        puerto_p1 <= g;
        ptr       <= g + 2'd1;
      end
    end
  end

  // Stage 1: FIFO read data arrives the cycle after the pop.
  always_comb begin
    dato_sel = '0;
    case (puerto_p1)
      2'd0:    dato_sel = bus.data_in4;
      2'd1:    dato_sel = bus.data_in5;
      2'd2:    dato_sel = bus.data_in6;
      default: dato_sel = bus.data_in7;
    endcase
  end

  assign bus.data_out  = vld_p1 ? dato_sel : '0;
  assign bus.valid_out = vld_p1;

  contadores_salida u_contadores (
    .clk          (clk),
    .reset        (reset),
    .incr         (vld_p1),
    .puerto       (puerto_p1),
    .req          (bus.req),
    .idx          (bus.idx),
    .cuenta       (bus.cuenta),
    .valid_cuenta (bus.valid_cuenta)
  );
endmodule

// File: tb/tb_arbitro_salida.sv
// Bench for arbitro_salida: FIFO model, data scoreboard, vector table and corner sequences.
module tb_arbitro_salida;
  import arbitro_salida_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  arbitro_salida_if bus();
  arbitro_salida dut (.clk(clk), .reset(reset), .bus(bus));

  int checks = 0;
  int errors = 0;

  dato_t fq [4][$];
  dato_t sb [$];

  typedef struct {
    logic       pausa;
    logic [3:0] exp_pop;
    logic       exp_vld;
  } vec_t;
  vec_t tabla [11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic refresca_empty();
    for (int i = 0; i < 4; i++) bus.fifo_empty[i] = (fq[i].size() == 0);
  endtask

  task automatic cargar(input int p, input dato_t d);
    fq[p].push_back(d);
    refresca_empty();
  endtask

  task automatic poner_dato(input int p, input dato_t d);
    case (p)
      0:       bus.data_in4 = d;
      1:       bus.data_in5 = d;
      2:       bus.data_in6 = d;
      default: bus.data_in7 = d;
    endcase
  endtask

  // One clock: check pop before the edge, model the FIFO read after it,
  // then check valid_out and data_out against the scoreboard.
  task automatic tick(input logic [3:0] exp_pop, input logic exp_vld, input string nm);
    logic [3:0] p;
    dato_t d;
    #1;
    p = bus.pop;
    chk({nm, "_pop"}, 32'(p), 32'(exp_pop));
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      if (p[i] && fq[i].size() > 0) begin
        d = fq[i].pop_front();
        poner_dato(i, d);
        sb.push_back(d);
      end
    end
    refresca_empty();
    @(negedge clk);
    chk({nm, "_valid"}, 32'(bus.valid_out), 32'(exp_vld));
    if (bus.valid_out === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL %s_data actual=%0h expected=none", nm, bus.data_out);
      end else begin
        d = sb.pop_front();
        chk({nm, "_data"}, 32'(bus.data_out), 32'(d));
      end
    end
  endtask

  task automatic leer(input logic [2:0] i, input cuenta_t exp, input string nm);
    bus.req = 1'b1;
    bus.idx = i;
    tick(4'b0000, 1'b0, nm);
    chk({nm, "_cuenta"}, 32'(bus.cuenta), 32'(exp));
    chk({nm, "_vcuenta"}, 32'(bus.valid_cuenta), 32'd1);
    bus.req = 1'b0;
  endtask

  task automatic aplicar_reset();
    reset     = 1'b0;
    bus.pausa = 1'b0;
    bus.req   = 1'b0;
    bus.idx   = 3'd0;
    for (int i = 0; i < 4; i++) begin
      fq[i].delete();
      poner_dato(i, '0);
    end
    sb.delete();
    refresca_empty();
    @(negedge clk);
    chk("rst_pop", 32'(bus.pop), 32'd0);
    chk("rst_data", 32'(bus.data_out), 32'd0);
    chk("rst_valid", 32'(bus.valid_out), 32'd0);
    chk("rst_cuenta", 32'(bus.cuenta), 32'd0);
    chk("rst_vcuenta", 32'(bus.valid_cuenta), 32'd0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    tabla[0]  = '{1'b0, 4'b0000, 1'b0};
    tabla[1]  = '{1'b0, 4'b0001, 1'b1};
    tabla[2]  = '{1'b0, 4'b0010, 1'b1};
    tabla[3]  = '{1'b0, 4'b0100, 1'b1};
    tabla[4]  = '{1'b0, 4'b1000, 1'b1};
    tabla[5]  = '{1'b0, 4'b0001, 1'b1};
    tabla[6]  = '{1'b1, 4'b0000, 1'b0};
    tabla[7]  = '{1'b1, 4'b0000, 1'b0};
    tabla[8]  = '{1'b0, 4'b0000, 1'b0};
    tabla[9]  = '{1'b0, 4'b0010, 1'b1};
    tabla[10] = '{1'b0, 4'b0100, 1'b1};

    // Round robin with all FIFOs loaded, pause mid-stream, resume from ptr.
    aplicar_reset();
    for (int k = 0; k < 4; k++)
      for (int j = 0; j < 6; j++) cargar(k, dato_t'(((k + 4) << 8) + j));
    for (int v = 0; v < 11; v++) begin
      bus.pausa = tabla[v].pausa;
      tick(tabla[v].exp_pop, tabla[v].exp_vld, $sformatf("rr%0d", v));
    end

    // Only port 6 holds three words.
    aplicar_reset();
    cargar(2, 12'h0A5);
    cargar(2, 12'h0B6);
    cargar(2, 12'h0C7);
    tick(4'b0000, 1'b0, "p6_ini");
    tick(4'b0100, 1'b1, "p6_a");
    tick(4'b0100, 1'b1, "p6_b");
    tick(4'b0100, 1'b1, "p6_c");
    tick(4'b0000, 1'b0, "p6_fin");

    // 33 words from port 4: counters wrap to 1.
    aplicar_reset();
    for (int j = 0; j < 33; j++) cargar(0, dato_t'(j + 12'h100));
    tick(4'b0000, 1'b0, "w_ini");
    for (int j = 0; j < 33; j++) tick(4'b0001, 1'b1, $sformatf("w_pop%0d", j));
    tick(4'b0000, 1'b0, "w_idle");
    leer(3'd0, cuenta_t'(1), "w_cnt0");
    leer(3'd6, cuenta_t'(0), "w_inval");
    leer(3'd4, cuenta_t'(1), "w_total");
    tick(4'b0000, 1'b0, "w_noreq");
    chk("w_noreq_vcuenta", 32'(bus.valid_cuenta), 32'd0);
    chk("w_noreq_hold", 32'(bus.cuenta), 32'd1);

    // Read of port 5 on the same edge as its increment returns the old value.
    aplicar_reset();
    cargar(1, 12'h511);
    cargar(1, 12'h522);
    cargar(1, 12'h533);
    tick(4'b0000, 1'b0, "c5_ini");
    tick(4'b0010, 1'b1, "c5_a");
    tick(4'b0010, 1'b1, "c5_b");
    tick(4'b0010, 1'b1, "c5_c");
    bus.req = 1'b1;
    bus.idx = 3'd1;
    tick(4'b0000, 1'b0, "c5_rd1");
    chk("c5_rd1_cuenta", 32'(bus.cuenta), 32'd2);
    chk("c5_rd1_vcuenta", 32'(bus.valid_cuenta), 32'd1);
    tick(4'b0000, 1'b0, "c5_rd2");
    chk("c5_rd2_cuenta", 32'(bus.cuenta), 32'd3);
    bus.req = 1'b0;

    // Asynchronous reset while a word is in flight.
    aplicar_reset();
    cargar(3, 12'h7E1);
    cargar(3, 12'h7E2);
    tick(4'b0000, 1'b0, "rs_ini");
    tick(4'b1000, 1'b1, "rs_a");
    #2;
    chk("rs_pop_pre", 32'(bus.pop), 32'b1000);
    reset = 1'b0;
    #1;
    chk("rs_pop_async", 32'(bus.pop), 32'd0);
    chk("rs_valid_async", 32'(bus.valid_out), 32'd0);
    chk("rs_data_async", 32'(bus.data_out), 32'd0);
    chk("rs_vcuenta_async", 32'(bus.valid_cuenta), 32'd0);
    sb.delete();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    tick(4'b0000, 1'b0, "rs_post0");
    tick(4'b1000, 1'b1, "rs_b");
    tick(4'b0000, 1'b0, "rs_idle");
    leer(3'd3, cuenta_t'(1), "rs_cnt7");
    leer(3'd4, cuenta_t'(1), "rs_total");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
